// File: rtl/axis_insert_header_arb.sv
// Packet-level round-robin arbiter that lets two requesters share one header inserter.
// A grant covers one header handshake plus every data beat up to and including the last one.
module axis_insert_header_arb #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    // requester 0
    input  logic                    s0_valid_insert,
    input  logic [DATA_WD-1:0]      s0_header_insert,
    input  logic [DATA_BYTE_WD-1:0] s0_keep_insert,
    input  logic [BYTE_CNT_WD:0]    s0_byte_insert_cnt,
    output logic                    s0_ready_insert,
    input  logic                    s0_valid_in,
    input  logic [DATA_WD-1:0]      s0_data_in,
    input  logic [DATA_BYTE_WD-1:0] s0_keep_in,
    input  logic                    s0_last_in,
    output logic                    s0_ready_in,
    // requester 1
    input  logic                    s1_valid_insert,
    input  logic [DATA_WD-1:0]      s1_header_insert,
    input  logic [DATA_BYTE_WD-1:0] s1_keep_insert,
    input  logic [BYTE_CNT_WD:0]    s1_byte_insert_cnt,
    output logic                    s1_ready_insert,
    input  logic                    s1_valid_in,
    input  logic [DATA_WD-1:0]      s1_data_in,
    input  logic [DATA_BYTE_WD-1:0] s1_keep_in,
    input  logic                    s1_last_in,
    output logic                    s1_ready_in,
    // towards the inserter
    output logic                    m_valid_insert,
    output logic [DATA_WD-1:0]      m_header_insert,
    output logic [DATA_BYTE_WD-1:0] m_keep_insert,
    output logic [BYTE_CNT_WD:0]    m_byte_insert_cnt,
    input  logic                    m_ready_insert,
    output logic                    m_valid_in,
    output logic [DATA_WD-1:0]      m_data_in,
    output logic [DATA_BYTE_WD-1:0] m_keep_in,
    output logic                    m_last_in,
    input  logic                    m_ready_in,
    // status
    output logic                    grant_id,
    output logic                    busy,
    output logic [15:0]             pkt_cnt0,
    output logic [15:0]             pkt_cnt1,
    output logic [1:0]              state_dbg
);

    // Handshake rule on every channel: a transfer happens on a posedge where valid and
    // ready are both high; ready here is a pure function of state, grant and the
    // downstream ready, so it never depends on the requester's own valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state;
    logic   prio;
    logic   hdr_phase;
    logic   data_phase;
    logic   hdr_hs;
    logic   last_hs;
    logic   arb_pick;

    logic                    sel_valid_insert;
    logic [DATA_WD-1:0]      sel_header_insert;
    logic [DATA_BYTE_WD-1:0] sel_keep_insert;
    logic [BYTE_CNT_WD:0]    sel_byte_insert_cnt;
    logic                    sel_valid_in;
    logic [DATA_WD-1:0]      sel_data_in;
    logic [DATA_BYTE_WD-1:0] sel_keep_in;
    logic                    sel_last_in;

    assign hdr_phase  = (state == HDR);
    assign data_phase = (state == DATA);
    assign state_dbg  = state;

    assign sel_valid_insert    = grant_id ? s1_valid_insert    : s0_valid_insert;
    assign sel_header_insert   = grant_id ? s1_header_insert   : s0_header_insert;
    assign sel_keep_insert     = grant_id ? s1_keep_insert     : s0_keep_insert;
    assign sel_byte_insert_cnt = grant_id ? s1_byte_insert_cnt : s0_byte_insert_cnt;
    assign sel_valid_in        = grant_id ? s1_valid_in        : s0_valid_in;
    assign sel_data_in         = grant_id ? s1_data_in         : s0_data_in;
    assign sel_keep_in         = grant_id ? s1_keep_in         : s0_keep_in;
    assign sel_last_in         = grant_id ? s1_last_in         : s0_last_in;

    // Outside its own phase each downstream channel is driven to all zeros.
    assign m_valid_insert    = hdr_phase & sel_valid_insert;
    assign m_header_insert   = hdr_phase ? sel_header_insert   : '0;
    assign m_keep_insert     = hdr_phase ? sel_keep_insert     : '0;
    assign m_byte_insert_cnt = hdr_phase ? sel_byte_insert_cnt : '0;
    assign m_valid_in        = data_phase & sel_valid_in;
    assign m_data_in         = data_phase ? sel_data_in : '0;
    assign m_keep_in         = data_phase ? sel_keep_in : '0;
    assign m_last_in         = data_phase & sel_last_in;

    assign s0_ready_insert = hdr_phase  & ~grant_id & m_ready_insert;
    assign s1_ready_insert = hdr_phase  &  grant_id & m_ready_insert;
    assign s0_ready_in     = data_phase & ~grant_id & m_ready_in;
    assign s1_ready_in     = data_phase &  grant_id & m_ready_in;

    assign hdr_hs   = m_valid_insert & m_ready_insert;
    assign last_hs  = m_valid_in & m_ready_in & m_last_in;
    assign arb_pick = (s0_valid_insert & s1_valid_insert) ? prio : s1_valid_insert;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prio     <= 1'b0;
            grant_id <= 1'b0;
            busy     <= 1'b0;
            pkt_cnt0 <= 16'd0;
            pkt_cnt1 <= 16'd0;
        end else begin
            // Counters are rewritten every cycle; the 16-bit add wraps 0xFFFF to 0.
            pkt_cnt0 <= pkt_cnt0 + {15'd0, last_hs & ~grant_id};
            pkt_cnt1 <= pkt_cnt1 + {15'd0, last_hs &  grant_id};
            case (state)
                IDLE: begin
                    if (s0_valid_insert | s1_valid_insert) begin
                        grant_id <= arb_pick;
                        state    <= HDR;
                        busy     <= 1'b1;
                    end
                end
                HDR: begin
                    if (hdr_hs) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (last_hs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        prio  <= ~grant_id;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_insert_header_arb.sv
// Randomised bench for axis_insert_header_arb: per-requester drivers feed expected queues,
// a negedge monitor runs a round-robin reference model and compares every handshake.
module tb_axis_insert_header_arb;

    localparam int TMO = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  s_valid_insert = '0;
    logic [31:0] s_header [2];
    logic [3:0]  s_keep_i [2];
    logic [2:0]  s_cnt [2];
    logic [1:0]  s_ready_insert;
    logic [1:0]  s_valid_in = '0;
    logic [31:0] s_data [2];
    logic [3:0]  s_keep_d [2];
    logic [1:0]  s_last = '0;
    logic [1:0]  s_ready_in;
    logic        m_valid_insert, m_valid_in, m_last_in;
    logic [31:0] m_header_insert, m_data_in;
    logic [3:0]  m_keep_insert, m_keep_in;
    logic [2:0]  m_byte_insert_cnt;
    logic        m_ready_insert = 1'b1;
    logic        m_ready_in = 1'b1;
    logic        grant_id, busy;
    logic [15:0] pkt_cnt0, pkt_cnt1;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    int rdy_mode = 0;

    // scoreboard: expected headers {hdr,keep,cnt} and beats {data,keep,last} per requester
    logic [38:0] exp_hdr_q0[$], exp_hdr_q1[$];
    logic [36:0] exp_dat_q0[$], exp_dat_q1[$];

    // reference model: phase 0 idle, 1 header, 2 data
    logic [1:0]  ph = 2'd0;
    logic        mg = 1'b0;
    logic        mprio = 1'b0;
    logic [15:0] mc0 = 16'd0, mc1 = 16'd0;

    axis_insert_header_arb dut (
        .clk(clk), .rst(rst),
        .s0_valid_insert(s_valid_insert[0]), .s0_header_insert(s_header[0]),
        .s0_keep_insert(s_keep_i[0]), .s0_byte_insert_cnt(s_cnt[0]),
        .s0_ready_insert(s_ready_insert[0]),
        .s0_valid_in(s_valid_in[0]), .s0_data_in(s_data[0]), .s0_keep_in(s_keep_d[0]),
        .s0_last_in(s_last[0]), .s0_ready_in(s_ready_in[0]),
        .s1_valid_insert(s_valid_insert[1]), .s1_header_insert(s_header[1]),
        .s1_keep_insert(s_keep_i[1]), .s1_byte_insert_cnt(s_cnt[1]),
        .s1_ready_insert(s_ready_insert[1]),
        .s1_valid_in(s_valid_in[1]), .s1_data_in(s_data[1]), .s1_keep_in(s_keep_d[1]),
        .s1_last_in(s_last[1]), .s1_ready_in(s_ready_in[1]),
        .m_valid_insert(m_valid_insert), .m_header_insert(m_header_insert),
        .m_keep_insert(m_keep_insert), .m_byte_insert_cnt(m_byte_insert_cnt),
        .m_ready_insert(m_ready_insert),
        .m_valid_in(m_valid_in), .m_data_in(m_data_in), .m_keep_in(m_keep_in),
        .m_last_in(m_last_in), .m_ready_in(m_ready_in),
        .grant_id(grant_id), .busy(busy), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // downstream ready generator
    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1: begin
                    m_ready_insert = ($urandom_range(3) != 0);
                    m_ready_in     = ($urandom_range(3) != 0);
                end
                2: begin
                    m_ready_insert = 1'b1;
                    m_ready_in     = ~m_ready_in;
                end
                default: begin
                    m_ready_insert = 1'b1;
                    m_ready_in     = 1'b1;
                end
            endcase
        end
    end

    // driver tasks
    task automatic wait_hs(input int k, input bit is_data, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < TMO; c++) begin
            @(negedge clk);
            if (rst) break;
            if (is_data ? s_ready_in[k] : s_ready_insert[k]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok && !rst) begin
            checks++;
            errors++;
            $display("FAIL hs_timeout: requester %0d got no handshake, required one within %0d cycles", k, TMO);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_pkt(input int k, input logic [31:0] hdr, input logic [3:0] hk,
                            input logic [2:0] hc, input int nb, input int bub,
                            input logic [3:0] lk);
        logic [31:0] d [16];
        logic [3:0]  kp;
        bit ok;
        for (int i = 0; i < nb; i++) begin
            d[i] = $urandom;
            kp = (i == nb - 1) ? lk : 4'hF;
            if (k == 0) exp_dat_q0.push_back({d[i], kp, i == nb - 1});
            else        exp_dat_q1.push_back({d[i], kp, i == nb - 1});
        end
        if (k == 0) exp_hdr_q0.push_back({hdr, hk, hc});
        else        exp_hdr_q1.push_back({hdr, hk, hc});
        s_valid_insert[k] = 1'b1;
        s_header[k] = hdr;
        s_keep_i[k] = hk;
        s_cnt[k] = hc;
        wait_hs(k, 1'b0, ok);
        s_valid_insert[k] = 1'b0;
        if (!ok) return;
        for (int i = 0; i < nb; i++) begin
            if (int'($urandom_range(99)) < bub) begin
                s_valid_in[k] = 1'b0;
                @(posedge clk); #1;
            end
            s_valid_in[k] = 1'b1;
            s_data[k] = d[i];
            s_keep_d[k] = (i == nb - 1) ? lk : 4'hF;
            s_last[k] = (i == nb - 1);
            wait_hs(k, 1'b1, ok);
            s_valid_in[k] = 1'b0;
            s_last[k] = 1'b0;
            if (!ok) return;
        end
    endtask

    task automatic run_requester(input int k, input int npk, input int maxgap, input int bub);
        for (int i = 0; i < npk; i++) begin
            repeat ($urandom_range(maxgap)) begin
                @(posedge clk); #1;
            end
            send_pkt(k, $urandom, 4'($urandom_range(15)), 3'($urandom_range(4)),
                     $urandom_range(1, 5), bub, 4'($urandom_range(1, 15)));
        end
    endtask

    // monitor with round-robin reference model
    task automatic monitor_step();
        logic        g, hv, dv;
        logic [6:0]  e, a;
        logic [38:0] eh;
        logic [36:0] eb;
        g  = mg;
        hv = s_valid_insert[g];
        dv = s_valid_in[g];
        e = {ph != 2'd0, ph == 2'd1 && hv, ph == 2'd2 && dv,
             ph == 2'd1 && g && m_ready_insert, ph == 2'd1 && !g && m_ready_insert,
             ph == 2'd2 && g && m_ready_in, ph == 2'd2 && !g && m_ready_in};
        a = {busy, m_valid_insert, m_valid_in, s_ready_insert, s_ready_in};
        check("ctrl", 64'(a), 64'(e));
        check("grant_id", 64'(grant_id), 64'(mg));
        check("pkt_cnt0", 64'(pkt_cnt0), 64'(mc0));
        check("pkt_cnt1", 64'(pkt_cnt1), 64'(mc1));
        check("hdr_bus", 64'({m_header_insert, m_keep_insert, m_byte_insert_cnt}),
              (ph == 2'd1) ? 64'({s_header[g], s_keep_i[g], s_cnt[g]}) : 64'd0);
        check("dat_bus", 64'({m_data_in, m_keep_in, m_last_in}),
              (ph == 2'd2) ? 64'({s_data[g], s_keep_d[g], s_last[g]}) : 64'd0);
        if (rst) begin
            ph = 2'd0; mg = 1'b0; mprio = 1'b0; mc0 = 16'd0; mc1 = 16'd0;
            exp_hdr_q0.delete(); exp_hdr_q1.delete();
            exp_dat_q0.delete(); exp_dat_q1.delete();
            return;
        end
        case (ph)
            2'd0: begin
                if (s_valid_insert != 2'b00) begin
                    mg = (s_valid_insert == 2'b11) ? mprio : s_valid_insert[1];
                    ph = 2'd1;
                end
            end
            2'd1: begin
                if (hv && m_ready_insert) begin
                    if ((g ? exp_hdr_q1.size() : exp_hdr_q0.size()) == 0) begin
                        check("hdr_unexpected", 64'(1), 64'(0));
                    end else begin
                        eh = g ? exp_hdr_q1.pop_front() : exp_hdr_q0.pop_front();
                        check("hdr_sb", 64'({m_header_insert, m_keep_insert, m_byte_insert_cnt}), 64'(eh));
                    end
                    ph = 2'd2;
                end
            end
            default: begin
                if (dv && m_ready_in) begin
                    if ((g ? exp_dat_q1.size() : exp_dat_q0.size()) == 0) begin
                        check("beat_unexpected", 64'(1), 64'(0));
                    end else begin
                        eb = g ? exp_dat_q1.pop_front() : exp_dat_q0.pop_front();
                        check("beat_sb", 64'({m_data_in, m_keep_in, m_last_in}), 64'(eb));
                        if (eb[0]) begin
                            ph = 2'd0;
                            mprio = ~g;
                            if (g) mc1 = mc1 + 16'd1;
                            else   mc0 = mc0 + 16'd1;
                        end
                    end
                end
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (mon_en) monitor_step();
    end

    // global time limit
    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            s_header[k] = '0; s_keep_i[k] = '0; s_cnt[k] = '0;
            s_data[k] = '0; s_keep_d[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // s0 alone, fixed header
        send_pkt(0, 32'h0F0E0D0C, 4'b0111, 3'd3, 4, 0, 4'hF);
        check("t1_grant", 64'(grant_id), 64'(0));
        check("t1_cnt0", 64'(pkt_cnt0), 64'(1));

        // simultaneous requests right after reset: s0 first, then alternating
        do_reset();
        fork
            run_requester(0, 3, 0, 0);
            run_requester(1, 3, 0, 0);
        join
        check("t2_cnt0", 64'(pkt_cnt0), 64'(3));
        check("t2_cnt1", 64'(pkt_cnt1), 64'(3));

        // toggling data ready
        rdy_mode = 2;
        send_pkt(0, 32'hA5A5_0001, 4'hF, 3'd4, 6, 0, 4'hF);
        rdy_mode = 0;

        // single-beat packet
        send_pkt(1, 32'h1234_5678, 4'h3, 3'd2, 1, 0, 4'b1100);
        @(negedge clk);
        check("t4_idle", 64'(busy), 64'(0));

        // randomised traffic on both requesters with backpressure
        rdy_mode = 1;
        fork
            run_requester(0, 8, 3, 30);
            run_requester(1, 8, 3, 30);
        join
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;

        // reset in the middle of an s1 data phase
        fork
            send_pkt(1, 32'hDEAD_BEEF, 4'hF, 3'd4, 8, 0, 4'hF);
            begin
                for (int c = 0; c < TMO; c++) begin
                    @(negedge clk);
                    if (ph == 2'd2 && mg) break;
                end
                @(negedge clk);
                @(posedge clk); #1;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                #1;
                check("t5_busy", 64'(busy), 64'(0));
                check("t5_ready", 64'({s_ready_insert, s_ready_in}), 64'(0));
                check("t5_cnt1", 64'(pkt_cnt1), 64'(0));
            end
        join

        // counter wrap
        @(posedge clk); #2;
        force dut.pkt_cnt0 = 16'hFFFF;
        mc0 = 16'hFFFF;
        @(posedge clk); #2;
        release dut.pkt_cnt0;
        send_pkt(0, 32'h0000_FFFF, 4'hF, 3'd4, 2, 0, 4'h1);
        check("t6_wrap", 64'(pkt_cnt0), 64'(0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("q_empty", 64'(exp_hdr_q0.size() + exp_hdr_q1.size() +
                             exp_dat_q0.size() + exp_dat_q1.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
